// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matmul control sequencer.
package matmul_pkg;

   localparam int MAX_DIM_DEF     = 4;
   localparam int SP_NTARGETS_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_PRELOAD = 3'd2,
      ST_FEED    = 3'd3,
      ST_WB      = 3'd4
   } sched_state_e;

   function automatic int dim_w(input int max_dim);
      return $clog2(max_dim);
   endfunction

   function automatic int tgt_w(input int n_targets);
      return $clog2(n_targets);
   endfunction

   // Feed length never exceeds MAX_DIM + 2*(MAX_DIM-1) = 3*MAX_DIM-2 steps.
   function automatic int step_w(input int max_dim);
      return $clog2(3 * max_dim - 2);
   endfunction

endpackage

// File: rtl/matmul_step_cnt.sv
// Phase step counter: synchronous clear, count enable and a terminal-value flag.
module matmul_step_cnt #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   input  logic         en_i,
   input  logic [W-1:0] last_val_i,
   output logic [W-1:0] cnt_o,
   output logic         last_o
);

   logic [W-1:0] cnt_d;
   logic [W-1:0] cnt_q;

   // Clear has priority so a phase change restarts the count at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = {W{1'b0}};
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign last_o = (cnt_q == last_val_i);

endmodule

// File: rtl/matmul_sched.sv
// Control sequencer for the matmul core: walks the systolic datapath through
// accumulator clear, optional C preload, skewed operand feed and row write-back.
module matmul_sched
   import matmul_pkg::*;
#(
   parameter  int MAX_DIM     = MAX_DIM_DEF,
   parameter  int SP_NTARGETS = SP_NTARGETS_DEF,
   localparam int DIM_W       = dim_w(MAX_DIM),
   localparam int TGT_W       = tgt_w(SP_NTARGETS),
   localparam int STEP_W      = step_w(MAX_DIM)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [DIM_W-1:0]  dim_n_i,
   input  logic [DIM_W-1:0]  dim_k_i,
   input  logic [DIM_W-1:0]  dim_m_i,
   input  logic              acc_mode_i,
   input  logic [TGT_W-1:0]  sp_target_i,
   output logic              pe_clr_o,
   output logic              rd_valid_o,
   output logic              acc_load_o,
   output logic              feed_valid_o,
   output logic [STEP_W-1:0] feed_step_o,
   output logic              wb_valid_o,
   output logic [DIM_W-1:0]  row_o,
   output logic [TGT_W-1:0]  target_o,
   output logic [DIM_W-1:0]  cfg_m_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              start_err_o
);

   localparam logic [STEP_W-1:0] DRAIN = STEP_W'(2 * (MAX_DIM - 1));

   sched_state_e      state_q, state_d;
   logic [DIM_W-1:0]  n_q, n_d, k_q, k_d, m_q, m_d;
   logic [TGT_W-1:0]  tgt_q, tgt_d;
   logic              acc_q, acc_d;
   logic              done_q, done_d;
   logic              start_err_q, start_err_d;
   logic              accept_s;
   logic              cnt_clr_s, cnt_en_s, cnt_last_s;
   logic [STEP_W-1:0] term_s, cnt_s;

   assign accept_s = (state_q == ST_IDLE) && start_i;

   matmul_step_cnt #(.W(STEP_W)) u_step_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (cnt_clr_s),
      .en_i       (cnt_en_s),
      .last_val_i (term_s),
      .cnt_o      (cnt_s),
      .last_o     (cnt_last_s)
   );

   // Phase sequencing; the shared counter is reprogrammed with each phase's last index.
   always_comb begin
      state_d   = state_q;
      cnt_clr_s = 1'b0;
      cnt_en_s  = 1'b0;
      term_s    = {STEP_W{1'b0}};
      done_d    = done_q;
      case (state_q)
         ST_IDLE: begin
            cnt_clr_s = 1'b1;
            if (start_i) begin
               state_d = ST_CLEAR;
               done_d  = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            cnt_clr_s = 1'b1;
            if (acc_q) begin
               state_d = ST_PRELOAD;
            end else begin
               state_d = ST_FEED;
            end
         end
         ST_PRELOAD: begin
            // N reads plus one trailing cycle to catch the last read's data.
            term_s = STEP_W'(n_q) + STEP_W'(1'b1);
            if (cnt_last_s) begin
               state_d   = ST_FEED;
               cnt_clr_s = 1'b1;
            end else begin
               cnt_en_s  = 1'b1;
            end
         end
         ST_FEED: begin
            term_s = STEP_W'(k_q) + DRAIN;
            if (cnt_last_s) begin
               state_d   = ST_WB;
               cnt_clr_s = 1'b1;
            end else begin
               cnt_en_s  = 1'b1;
            end
         end
         ST_WB: begin
            term_s = STEP_W'(n_q);
            if (cnt_last_s) begin
               state_d   = ST_IDLE;
               cnt_clr_s = 1'b1;
               done_d    = 1'b1;
            end else begin
               cnt_en_s  = 1'b1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            cnt_clr_s = 1'b1;
         end
      endcase
   end

   // Descriptor is captured only on an accepted start; a rejected start just flags an error.
   always_comb begin
      start_err_d = start_i && (state_q != ST_IDLE);
      if (accept_s) begin
         n_d   = dim_n_i;
         k_d   = dim_k_i;
         m_d   = dim_m_i;
         acc_d = acc_mode_i;
         tgt_d = sp_target_i;
      end else begin
         n_d   = n_q;
         k_d   = k_q;
         m_d   = m_q;
         acc_d = acc_q;
         tgt_d = tgt_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         n_q         <= {DIM_W{1'b0}};
         k_q         <= {DIM_W{1'b0}};
         m_q         <= {DIM_W{1'b0}};
         acc_q       <= 1'b0;
         tgt_q       <= {TGT_W{1'b0}};
         done_q      <= 1'b0;
         start_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         k_q         <= k_d;
         m_q         <= m_d;
         acc_q       <= acc_d;
         tgt_q       <= tgt_d;
         done_q      <= done_d;
         start_err_q <= start_err_d;
      end
   end

   // Datapath strobes decoded from registered state and counter only.
   always_comb begin
      pe_clr_o     = 1'b0;
      rd_valid_o   = 1'b0;
      acc_load_o   = 1'b0;
      feed_valid_o = 1'b0;
      feed_step_o  = {STEP_W{1'b0}};
      wb_valid_o   = 1'b0;
      row_o        = {DIM_W{1'b0}};
      case (state_q)
         ST_CLEAR: begin
            pe_clr_o = 1'b1;
         end
         ST_PRELOAD: begin
            rd_valid_o = !cnt_last_s;
            acc_load_o = (cnt_s != {STEP_W{1'b0}});
            row_o      = cnt_last_s ? {DIM_W{1'b0}} : cnt_s[DIM_W-1:0];
         end
         ST_FEED: begin
            feed_valid_o = 1'b1;
            feed_step_o  = cnt_s;
         end
         ST_WB: begin
            wb_valid_o = 1'b1;
            row_o      = cnt_s[DIM_W-1:0];
         end
         default: begin
            pe_clr_o = 1'b0;
         end
      endcase
   end

   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = done_q;
   assign start_err_o = start_err_q;
   assign target_o    = tgt_q;
   assign cfg_m_o     = m_q;

endmodule

// File: tb/tb_matmul_sched.sv
// Self-checking bench for matmul_sched: table of descriptors with hand-derived
// phase lengths, checked cycle by cycle, plus reset and restart sequences.
module tb_matmul_sched;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       start_i = 1'b0;
   logic [1:0] dim_n_i = 2'd0, dim_k_i = 2'd0, dim_m_i = 2'd0;
   logic       acc_mode_i = 1'b0;
   logic [1:0] sp_target_i = 2'd0;
   logic       pe_clr_o, rd_valid_o, acc_load_o, feed_valid_o, wb_valid_o;
   logic [3:0] feed_step_o;
   logic [1:0] row_o, target_o, cfg_m_o;
   logic       busy_o, done_o, start_err_o;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic       pe_clr;
      logic       rd;
      logic       al;
      logic       fv;
      logic [3:0] step;
      logic       wb;
      logic [1:0] row;
      logic       busy;
      logic       done;
      logic       err;
   } obs_t;

   // Inputs (real dimensions, acc, target, optional stray start) and hand-computed phase lengths.
   typedef struct {
      int n; int k; int m; int acc; int tgt;
      int err_cyc; int err_tgt;
      int pre; int feed; int wb;
   } vec_t;

   vec_t vecs[5];

   matmul_sched #(.MAX_DIM(4), .SP_NTARGETS(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
      .dim_n_i(dim_n_i), .dim_k_i(dim_k_i), .dim_m_i(dim_m_i),
      .acc_mode_i(acc_mode_i), .sp_target_i(sp_target_i),
      .pe_clr_o(pe_clr_o), .rd_valid_o(rd_valid_o), .acc_load_o(acc_load_o),
      .feed_valid_o(feed_valid_o), .feed_step_o(feed_step_o), .wb_valid_o(wb_valid_o),
      .row_o(row_o), .target_o(target_o), .cfg_m_o(cfg_m_o),
      .busy_o(busy_o), .done_o(done_o), .start_err_o(start_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.pe_clr = pe_clr_o;  o.rd = rd_valid_o;   o.al = acc_load_o;
      o.fv = feed_valid_o;  o.step = feed_step_o; o.wb = wb_valid_o;
      o.row = row_o;        o.busy = busy_o;      o.done = done_o;
      o.err = start_err_o;
      return o;
   endfunction

   // Expected strobes in cycle c after the start edge, from the table's phase lengths.
   function automatic obs_t expect_at(input int c, input vec_t v);
      obs_t e;
      int   p;
      e = '0;
      e.err = (v.err_cyc != 0) && (c == v.err_cyc + 1);
      if (c == 1) begin
         e.pe_clr = 1'b1; e.busy = 1'b1;
      end else if (c - 2 < v.pre) begin
         p = c - 2;
         e.busy = 1'b1;
         e.rd   = (p < v.pre - 1);
         e.row  = e.rd ? 2'(p) : 2'd0;
         e.al   = (p >= 1);
      end else if (c - 2 - v.pre < v.feed) begin
         p = c - 2 - v.pre;
         e.busy = 1'b1; e.fv = 1'b1; e.step = 4'(p);
      end else if (c - 2 - v.pre - v.feed < v.wb) begin
         p = c - 2 - v.pre - v.feed;
         e.busy = 1'b1; e.wb = 1'b1; e.row = 2'(p);
      end else begin
         e.done = 1'b1;
      end
      return e;
   endfunction

   task automatic apply_start(input vec_t v);
      dim_n_i = 2'(v.n - 1); dim_k_i = 2'(v.k - 1); dim_m_i = 2'(v.m - 1);
      acc_mode_i = (v.acc != 0); sp_target_i = 2'(v.tgt);
      start_i = 1'b1;
      tick;
      start_i = 1'b0;
      // Scramble the descriptor inputs to prove they were latched.
      dim_n_i = ~dim_n_i; dim_k_i = ~dim_k_i; dim_m_i = ~dim_m_i;
      acc_mode_i = ~acc_mode_i; sp_target_i = ~sp_target_i;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int total;
      total = 1 + v.pre + v.feed + v.wb;
      apply_start(v);
      for (int c = 1; c <= total + 2; c++) begin
         check($sformatf("vec%0d cyc%0d strobes", idx, c), 32'(sample()), 32'(expect_at(c, v)));
         check($sformatf("vec%0d cyc%0d target/cfg_m", idx, c),
               {28'd0, target_o, cfg_m_o}, {28'd0, 2'(v.tgt), 2'(v.m - 1)});
         if (c == v.err_cyc) begin
            start_i = 1'b1; sp_target_i = 2'(v.err_tgt);
         end else begin
            start_i = 1'b0;
         end
         tick;
      end
      start_i = 1'b0;
   endtask

   initial begin
      //        n  k  m acc tgt errc errt pre feed wb
      vecs[0] = '{4, 4, 3, 0, 2, 0, 0, 0, 10, 4};
      vecs[1] = '{2, 1, 2, 1, 1, 0, 0, 3, 7,  2};
      vecs[2] = '{4, 4, 1, 0, 2, 5, 1, 0, 10, 4};
      vecs[3] = '{1, 1, 4, 1, 3, 0, 0, 2, 7,  1};
      vecs[4] = '{3, 2, 2, 0, 0, 1, 3, 0, 8,  3};

      // Reset held: everything quiet.
      #12;
      check("reset outputs", {18'd0, sample(), target_o, cfg_m_o}, 32'd0);
      #3 rst_ni = 1'b1;
      tick;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("idle cyc%0d", i), {18'd0, sample(), target_o, cfg_m_o}, 32'd0);
         tick;
      end

      // Back-to-back runs: each start after the first lands with done_o already high.
      for (int i = 0; i < 5; i++) begin
         run_vec(i, vecs[i]);
      end

      // Reset during WB row 1 of an N=K=4 run.
      apply_start(vecs[0]);
      for (int c = 1; c < 13; c++) tick;
      check("pre-reset wb row1", {28'd0, wb_valid_o, 1'b0, row_o}, {28'd0, 1'b1, 1'b0, 2'd1});
      #2 rst_ni = 1'b0;
      #1;
      check("mid-wb reset outputs", {18'd0, sample(), target_o, cfg_m_o}, 32'd0);
      #2 rst_ni = 1'b1;
      tick;
      check("post-reset idle", 32'(sample()), 32'd0);
      tick;
      check("post-reset done stays low", {31'd0, done_o}, 32'd0);

      // A fresh start after the aborted run completes normally.
      run_vec(5, vecs[3]);
      run_vec(6, vecs[1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/matmul_sched.md
# matmul_sched

Control sequencer for the matmul accelerator core. It sits between the APB register file and the systolic datapath. On a start strobe it latches the operation descriptor and walks the datapath through five phases:

- clear the PE accumulators;
- optionally preload the old C rows from the scratchpad;
- feed skewed operands;
- write result rows back to the selected scratchpad target;
- flag completion.

It owns `busy_o`/`done_o` for the top level.

## Interface

Parameters:

- `MAX_DIM`, 4: systolic array edge; maximum N, K, M.
- `SP_NTARGETS`, 4: number of scratchpad targets.
- Derived, not overridable:
  - `DIM_W = $clog2(MAX_DIM)`
  - `TGT_W = $clog2(SP_NTARGETS)`
  - `STEP_W = $clog2(3*MAX_DIM-2)`

Ports (clock `clk_i`; reset `rst_ni` is asynchronous, active-low):

- `clk_i` in 1: core clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `start_i` in 1: one-cycle start strobe from the control-register write.
- `dim_n_i` in `DIM_W`: rows of A/C, encoded value-1.
- `dim_k_i` in `DIM_W`: inner dimension, encoded value-1.
- `dim_m_i` in `DIM_W`: columns of B/C, encoded value-1. Latched and exported only.
- `acc_mode_i` in 1: 1 = C += A·B (preload old C); 0 = C = A·B.
- `sp_target_i` in `TGT_W`: destination scratchpad for C.
- `pe_clr_o` out 1: accumulator clear pulse.
- `rd_valid_o` out 1: scratchpad C-row read request (preload).
- `acc_load_o` out 1: load returned read data into PE row `row_o` of the previous cycle.
- `feed_valid_o` out 1: operand feed step active.
- `feed_step_o` out `STEP_W`: current feed step index.
- `wb_valid_o` out 1: write result row `row_o`.
- `row_o` out `DIM_W`: row index for `rd_valid_o` / `wb_valid_o`.
- `target_o` out `TGT_W`: latched scratchpad target.
- `cfg_m_o` out `DIM_W`: latched `dim_m`, for datapath column masking.
- `busy_o` out 1: operation in progress.
- `done_o` out 1: sticky completion flag.
- `start_err_o` out 1: pulse when start is rejected.

## Operation

States: IDLE, CLEAR, PRELOAD, FEED, WB. Let N, K be the decoded values, range 1..`MAX_DIM`.

- **IDLE**
  - `start_i` = 1: latch all descriptor inputs, clear `done_o`, go to CLEAR.
- **CLEAR** (1 cycle)
  - `pe_clr_o` = 1.
  - Next state: PRELOAD if `acc_mode`, else FEED.
- **PRELOAD** (N+1 cycles, local index p = 0..N)
  - `rd_valid_o` = 1 and `row_o` = p while p < N.
  - `acc_load_o` = 1 for p ≥ 1, covering the scratchpad's 1-cycle read latency.
  - Go to FEED after p = N.
- **FEED** (L = K + 2·(`MAX_DIM`-1) cycles)
  - `feed_valid_o` = 1; `feed_step_o` counts 0..L-1.
  - The datapath zeroes operands for step ≥ K; the remaining steps drain the skew.
  - Go to WB after step L-1.
- **WB** (N cycles)
  - `wb_valid_o` = 1, `row_o` = 0..N-1.
  - After the last row: go to IDLE and set `done_o`.

General behaviour:

- `busy_o` = 1 in every state except IDLE.
- `start_i` while `busy_o` = 1: ignored, with a 1-cycle `start_err_o` pulse. The descriptor is not re-latched and the phase is not disturbed.
- `start_i` in IDLE while `done_o` = 1: accepted; `done_o` drops on the same edge.
- Unused outputs are 0 in each state. `row_o` and `feed_step_o` are 0 when not qualified by their valid signals.
- `target_o` and `cfg_m_o` hold their latched values until the next accepted start.

## Timing

- Reset value of every output is 0. The state is IDLE.
- Reset asserted mid-operation returns to IDLE immediately. The in-flight operation is discarded and `done_o` is not set.
- All outputs are registered, or decoded from registered state and counters only. There is no combinational path from `start_i`.
- Start sampled at edge 0:
  - CLEAR at cycle 1.
  - Non-acc: FEED at cycles 2..L+1, WB at L+2..L+N+1, `done_o` high from cycle L+N+2.
  - Acc mode adds N+1 cycles before FEED.
- The edge cases N=1 and K=1 must still produce exactly 1 PRELOAD read, L = 1+2·(`MAX_DIM`-1) feed steps, and 1 WB row.

## Structure

- `matmul_pkg` holds:
  - the `sched_state_e` enum;
  - the `MAX_DIM` default;
  - the derived width functions and constants.
- One sub-module, `matmul_step_cnt`: a loadable up-counter with `clear`, `en` and a `last` flag at a programmable terminal value. It is instantiated once and reused for the PRELOAD, FEED and WB phase counters.

## Test plan

Test plan with `MAX_DIM` = 4:

- **Reset:** hold `rst_ni` = 0 → all outputs 0. Release, then idle 10 cycles → `busy_o` = 0, no strobes.
- **Non-acc, N=K=4:** start at cycle 0 → `pe_clr_o` at cycle 1; `feed_step_o` 0..9 at cycles 2..11; `wb_valid_o` rows 0..3 at cycles 12..15; `done_o` = 1 from cycle 16.
- **Acc, N=2, K=1:** start → CLEAR; `rd_valid_o` rows 0,1; `acc_load_o` the 2 following cycles; 7 feed steps; 2 WB rows; `done_o`.
- **Start while busy:** second `start_i` mid-FEED with a different target → one `start_err_o` pulse; `target_o` and timing unchanged.
- **Reset mid-WB:** assert `rst_ni` low during row 1 → immediate IDLE, `done_o` = 0. A new start runs a full sequence.
- **Restart after done:** start while `done_o` = 1 → `done_o` clears the next cycle; the second run completes with the new `target_o`.
